// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path types and helpers for the RV instruction realignment logic.
// A halfword whose low two bits are not 2'b11 starts a 16-bit RVC parcel.
package rv_fetch_pkg;

  localparam int ILEN = 32;
  localparam logic [1:0] RVC_QUAD_FULL = 2'b11;

  typedef logic [15:0] halfword_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_READY
  } align_state_e;

  function automatic logic is_compr(input halfword_t hw);
    return hw[1:0] != RVC_QUAD_FULL;
  endfunction

endpackage

// File: rtl/hw_ring_buf.sv
// Circular halfword buffer: multi-halfword write with a low-lane drop offset,
// two-halfword peek at the head, and pop of one or two halfwords.
module hw_ring_buf
  import rv_fetch_pkg::*;
#(
  parameter int HPF      = 2,
  parameter int DEPTH_HW = 8,
  localparam int AW      = $clog2(DEPTH_HW),
  localparam int CW      = AW + 1,
  localparam int DROP_W  = (HPF > 1) ? $clog2(HPF) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [HPF*16-1:0] wr_data,
  input  logic [DROP_W-1:0] wr_drop,
  input  logic              rd_en,
  input  logic              rd_two,
  output halfword_t         peek0,
  output halfword_t         peek1,
  output logic [CW-1:0]     count
);

  halfword_t mem [DEPTH_HW];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] wr_idx [HPF];
  logic [HPF-1:0] wr_lane;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;

  // Lane i of the fetch word lands at tail + (i - drop); dropped lanes are skipped.
  always_comb begin
    wr_lane = '0;
    for (int i = 0; i < HPF; i++) begin
      wr_idx[i]  = tail + AW'(i) - AW'(wr_drop);
      wr_lane[i] = wr_en && (i >= int'(wr_drop));
    end
    push_n = wr_en ? (CW'(HPF) - CW'(wr_drop)) : '0;
    pop_n  = rd_en ? (rd_two ? CW'(2) : CW'(1)) : '0;
  end

  assign peek0 = mem[head];
  assign peek1 = mem[head + AW'(1)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count + push_n - pop_n;
    end
  end

  // Storage carries no reset; consumers only look at it when count says it is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < HPF; i++) begin
      if (wr_lane[i]) mem[wr_idx[i]] <= wr_data[16*i +: 16];
    end
  end

endmodule

// File: rtl/instr_realign_buf.sv
// Realigns fetch words into one RVC parcel or 32-bit instruction per handshake,
// tracking the instruction PC and honouring redirect flushes.
//   state      | meaning
//   ST_EMPTY   | no halfwords buffered
//   ST_PARTIAL | one halfword buffered, it starts a 32-bit instruction
//   ST_READY   | a complete instruction sits at the head
module instr_realign_buf
  import rv_fetch_pkg::*;
#(
  parameter int              FETCH_W  = 32,
  parameter int              DEPTH_HW = 8,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [FETCH_W-1:0] fetch_data,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ILEN-1:0]    out_instr,
  output logic               out_compr,
  output logic [PC_W-1:0]    out_pc
);

  localparam int HPF    = FETCH_W / 16;
  localparam int AW     = $clog2(DEPTH_HW);
  localparam int CW     = AW + 1;
  localparam int DROP_W = (HPF > 1) ? $clog2(HPF) : 1;

  halfword_t       h0;
  halfword_t       h1;
  logic [CW-1:0]   count;
  logic [DROP_W-1:0] drop;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] flush_target;
  logic            compr;
  logic            push;
  logic            pop;
  align_state_e    state;

  hw_ring_buf #(
    .HPF      (HPF),
    .DEPTH_HW (DEPTH_HW)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (push),
    .wr_data (fetch_data),
    .wr_drop (drop),
    .rd_en   (pop),
    .rd_two  (!compr),
    .peek0   (h0),
    .peek1   (h1),
    .count   (count)
  );

  assign flush_target = flush_pc & ~PC_W'(1);
  assign compr        = is_compr(h0);

  always_comb begin
    state = ST_READY;
    if (count == '0) begin
      state = ST_EMPTY;
    end else if (count == CW'(1) && !compr) begin
      state = ST_PARTIAL;
    end
  end

  // Space check uses only the registered count; a same-cycle pop does not help.
  assign fetch_ready = (CW'(DEPTH_HW) - count) >= CW'(HPF);
  assign push        = fetch_valid && fetch_ready && !flush;
  assign out_valid   = (state == ST_READY);
  assign pop         = out_valid && out_ready && !flush;

  assign out_compr = out_valid && compr;
  assign out_instr = !out_valid ? '0 :
                     compr      ? {{(ILEN-16){1'b0}}, h0} : {h1, h0};
  assign out_pc    = pc;

  // The redirect target's offset within the fetch word becomes the lane drop count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= RESET_PC;
      drop <= '0;
    end else if (flush) begin
      pc   <= flush_target;
      drop <= flush_target[DROP_W:1];
    end else begin
      if (pop)  pc   <= pc + (compr ? PC_W'(2) : PC_W'(4));
      if (push) drop <= '0;
    end
  end

endmodule

// File: tb/tb_instr_realign_buf.sv
// Randomized and directed check of instr_realign_buf against a halfword-queue
// reference model (FETCH_W=32, DEPTH_HW=4, RESET_PC=0).
module tb_instr_realign_buf;

  localparam int FETCH_W  = 32;
  localparam int DEPTH_HW = 4;
  localparam int PC_W     = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fetch_valid = 1'b0;
  logic               fetch_ready;
  logic [FETCH_W-1:0] fetch_data = '0;
  logic               flush = 1'b0;
  logic [PC_W-1:0]    flush_pc = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [31:0]        out_instr;
  logic               out_compr;
  logic [PC_W-1:0]    out_pc;

  always #5 clk = ~clk;

  instr_realign_buf #(
    .FETCH_W  (FETCH_W),
    .DEPTH_HW (DEPTH_HW),
    .PC_W     (PC_W),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_compr   (out_compr),
    .out_pc      (out_pc)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mq[$];
  logic [31:0] mpc;
  int          mdrop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = 32'h0;
    mdrop = 0;
  endtask

  // Apply one cycle of inputs, compare outputs with the model, clock, update the model.
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic f, input logic [31:0] fp);
    logic        exp_ready;
    logic        exp_valid;
    logic        exp_compr;
    logic [31:0] exp_instr;
    fetch_valid = v;
    fetch_data  = d;
    out_ready   = r;
    flush       = f;
    flush_pc    = fp;
    #1;
    exp_ready = (DEPTH_HW - mq.size()) >= 2;
    exp_valid = 1'b0;
    exp_compr = 1'b0;
    exp_instr = 32'h0;
    if (mq.size() >= 1) begin
      exp_compr = (mq[0][1:0] != 2'b11);
      exp_valid = exp_compr || (mq.size() >= 2);
      if (exp_compr) exp_instr = {16'h0, mq[0]};
      else if (mq.size() >= 2) exp_instr = {mq[1], mq[0]};
    end
    chk("fetch_ready", 64'(fetch_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_pc", 64'(out_pc), 64'(mpc));
    if (exp_valid) begin
      chk("out_instr", 64'(out_instr), 64'(exp_instr));
      chk("out_compr", 64'(out_compr), 64'(exp_compr));
    end
    @(posedge clk);
    #1;
    if (f) begin
      mq.delete();
      mpc   = fp & ~32'd1;
      mdrop = int'(fp[1]);
    end else begin
      if (exp_valid && r) begin
        void'(mq.pop_front());
        if (!exp_compr) void'(mq.pop_front());
        mpc = mpc + (exp_compr ? 32'd2 : 32'd4);
      end
      if (v && exp_ready) begin
        for (int i = mdrop; i < 2; i++) mq.push_back(d[16*i +: 16]);
        mdrop = 0;
      end
    end
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    return h;
  endfunction

  initial begin
    model_reset();
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_compr", 64'(out_compr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill to 3 halfwords, then reset asynchronously mid-cycle
    step(1'b1, 32'h0001_0001, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0001_0001, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("pre_rst_pc", 64'(out_pc), 64'h2);
    fetch_valid = 1'b0;
    out_ready   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single 32-bit instruction
    step(1'b1, 32'hB16B_00B7, 1'b1, 1'b0, 32'h0);
    chk("t2_instr", 64'(out_instr), 64'hB16B_00B7);
    chk("t2_compr", 64'(out_compr), 64'd0);
    chk("t2_pc", 64'(out_pc), 64'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t2_pc_after", 64'(out_pc), 64'h4);
    chk("t2_valid_after", 64'(out_valid), 64'd0);

    // Two RVC parcels in one word
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h8E15_9482, 1'b1, 1'b0, 32'h0);
    chk("t3_instr0", 64'(out_instr), 64'h0000_9482);
    chk("t3_compr0", 64'(out_compr), 64'd1);
    chk("t3_pc0", 64'(out_pc), 64'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t3_instr1", 64'(out_instr), 64'h0000_8E15);
    chk("t3_pc1", 64'(out_pc), 64'h2);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t3_valid_end", 64'(out_valid), 64'd0);

    // Straddling 32-bit instruction through PARTIAL
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'hBEAF_E8AC, 1'b1, 1'b0, 32'h0);
    chk("t4_instr0", 64'(out_instr), 64'h0000_E8AC);
    chk("t4_pc0", 64'(out_pc), 64'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t4_partial", 64'(out_valid), 64'd0);
    step(1'b1, 32'hCAFE_BEEF, 1'b1, 1'b0, 32'h0);
    chk("t4_straddle", 64'(out_instr), 64'hBEEF_BEAF);
    chk("t4_straddle_pc", 64'(out_pc), 64'h2);
    chk("t4_straddle_compr", 64'(out_compr), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t4_tail", 64'(out_instr), 64'h0000_CAFE);
    chk("t4_tail_pc", 64'(out_pc), 64'h6);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Flush to a mid-word target with a fetch offered in the flush cycle
    step(1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h102);
    chk("t5_valid_post_flush", 64'(out_valid), 64'd0);
    chk("t5_pc_post_flush", 64'(out_pc), 64'h102);
    step(1'b1, 32'hCAFE_BEEF, 1'b0, 1'b0, 32'h0);
    chk("t5_instr", 64'(out_instr), 64'h0000_CAFE);
    chk("t5_pc", 64'(out_pc), 64'h102);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t5_sole", 64'(out_valid), 64'd0);

    // Fill to capacity, stall, then drain across the wrap point
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h0000_0003, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    chk("t6_full_ready", 64'(fetch_ready), 64'd0);
    chk("t6_instr0", 64'(out_instr), 64'h0000_0003);
    step(1'b1, 32'h1234_567B, 1'b0, 1'b0, 32'h0);
    chk("t6_stall_ready", 64'(fetch_ready), 64'd0);
    step(1'b1, 32'h1234_567B, 1'b1, 1'b0, 32'h0);
    chk("t6_ready_back", 64'(fetch_ready), 64'd1);
    chk("t6_instr1", 64'(out_instr), 64'hFFFF_FFFF);
    chk("t6_pc1", 64'(out_pc), 64'h4);
    step(1'b1, 32'h1234_567B, 1'b1, 1'b0, 32'h0);
    chk("t6_wrap_instr", 64'(out_instr), 64'h1234_567B);
    chk("t6_wrap_pc", 64'(out_pc), 64'h8);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t6_end_valid", 64'(out_valid), 64'd0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] d;
      d = {rand_hw(), rand_hw()};
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0, 32'($urandom_range(0, 32'hFFFF)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
